pc_register: RTL and testbench
==============================

Name: pc_register

Overview:
- Program counter register for the single-cycle MIPS CPU.
- Each rising clock edge loads either the sequential successor of the previous PC (PC_last + 4) or an externally supplied branch/jump/reset target (alternative_PC).
- Sits at the front of the fetch path. Its output drives instruction-memory addressing, and it is fed back as PC_last by the surrounding datapath.

Parameters:
- WIDTH, 32, bit width of all address ports.
- INCREMENT, 4, byte step added to PC_last on sequential fetch.
- RESET_VALUE, 32'h0000_0000, value forced onto PC by reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset. Forces PC to RESET_VALUE. When left unconnected (z), it must behave as deasserted.
- PC  output  WIDTH  registered current program counter.
- PC_last  input  WIDTH  previous PC value supplied by the datapath; base for sequential increment.
- alternative_PC  input  WIDTH  non-sequential target (branch, jump, software reset vector).
- use_alternative_PC  input  1  select; 1 = load alternative_PC, 0 = load PC_last + INCREMENT.

Behaviour:
- Single WIDTH-bit register; PC is the register output directly, with no combinational path from inputs to PC.
- Reset:
  - While reset = 1, PC = RESET_VALUE immediately, without waiting for a clock edge.
  - Reset dominates any simultaneous clock edge.
  - Deassertion takes effect at the next rising edge, with normal select rules.
- Rising edge of clk with reset = 0:
  - use_alternative_PC = 1 → PC <= alternative_PC, passed unmodified. No alignment check; low bits are preserved.
  - use_alternative_PC = 0 → PC <= PC_last + INCREMENT, unsigned, modulo 2^WIDTH. Example: 32'hFFFF_FFFC + 4 → 32'h0000_0000, with no carry/overflow flag.
- use_alternative_PC = x/z is treated as 0 (sequential path) for synthesis purposes. Verification must not rely on this.
- Latency: exactly one clock. Inputs sampled at a rising edge are visible on PC immediately after that edge and held until the next edge.
- Inputs may change freely between edges; only values at the rising edge matter. Setup/hold is the standard single-clock requirement.
- No enable/stall: PC updates on every rising edge not under reset.
- Power-up before any reset or edge: PC undefined in simulation. A reset pulse, or one edge with use_alternative_PC = 1, establishes a known value.

Test Plan:
- Alternative-PC reset: drive PC_last = 4, alternative_PC = 0, use_alternative_PC = 1 on the negedge → PC = 0 after the next rising edge, and still 0 when checked one full cycle later.
- Sequential increment: PC_last = 0, alternative_PC = 0, use_alternative_PC = 0 → PC = 4 after one rising edge.
- Alternative target: PC_last = 4, alternative_PC = 8, use_alternative_PC = 1 → PC = 8 (not 8 from increment coincidence; repeat with alternative_PC = 32'h0040_0020 → PC = 32'h0040_0020).
- Wrap-around: PC_last = 32'hFFFF_FFFC, use_alternative_PC = 0 → PC = 32'h0000_0000.
- Asynchronous reset: with PC = 32'h100, pulse reset = 1 mid-cycle, away from the clock edge → PC = 0 before any further clock edge. Keep reset asserted across a rising edge with use_alternative_PC = 1, alternative_PC = 8 → PC stays 0. Deassert → next edge loads per select.
- Hold between edges: change PC_last/alternative_PC/use_alternative_PC several times between rising edges → PC unchanged until the edge, then reflects only the edge-sampled values.

Source files
------------

// File: rtl/pc_register.sv
// rtl/pc_register.sv - MIPS program counter: loads PC_last + INCREMENT or an alternative target each edge
module pc_register #(
    parameter int unsigned          WIDTH       = 32,
    parameter int unsigned          INCREMENT   = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] PC_last,
    input  logic [WIDTH-1:0] alternative_PC,
    input  logic             use_alternative_PC
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_next_pc;

    // Sequential successor wraps modulo 2^WIDTH; no carry is reported.
    assign w_seq_pc  = PC_last + STEP;
    assign w_next_pc = use_alternative_PC ? alternative_PC : w_seq_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_VALUE;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign PC = r_pc;

endmodule

// File: tb/tb_pc_register.sv
// tb/tb_pc_register.sv - directed self-checking bench for pc_register
module tb_pc_register;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] PC_last;
    logic [31:0] alternative_PC;
    logic        use_alternative_PC;

    int total;
    int bad;

    pc_register #(
        .WIDTH       (32),
        .INCREMENT   (4),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .PC                 (PC),
        .PC_last            (PC_last),
        .alternative_PC     (alternative_PC),
        .use_alternative_PC (use_alternative_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] last, input logic [31:0] alt, input logic use_alt);
        PC_last            = last;
        alternative_PC     = alt;
        use_alternative_PC = use_alt;
    endtask

    // Inputs set on the falling edge, result sampled 1 time unit after the rising edge.
    task automatic step(input logic [31:0] last, input logic [31:0] alt, input logic use_alt);
        @(negedge clk);
        drive(last, alt, use_alt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(32'h4, 32'h0, 1'b0);
        #1;
        check("reset_async_initial", PC, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", PC, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;

        step(32'h4, 32'h0, 1'b1);
        check("alt_reset_first_edge", PC, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("alt_reset_cycle_later", PC, 32'h0000_0000);

        step(32'h0, 32'h0, 1'b0);
        check("seq_0_to_4", PC, 32'h0000_0004);

        step(32'h4, 32'h8, 1'b1);
        check("alt_target_8", PC, 32'h0000_0008);

        step(32'h4, 32'h0040_0020, 1'b1);
        check("alt_target_400020", PC, 32'h0040_0020);

        step(32'h4, 32'h0000_0003, 1'b1);
        check("alt_unaligned_kept", PC, 32'h0000_0003);

        step(32'h0040_0020, 32'h0000_0100, 1'b0);
        check("seq_400020", PC, 32'h0040_0024);

        step(32'hFFFF_FFFC, 32'h1234_5678, 1'b0);
        check("seq_wraparound", PC, 32'h0000_0000);

        step(32'h8000_0000, 32'h0, 1'b0);
        check("seq_high_bit", PC, 32'h8000_0004);

        // Hold: several input changes between edges must not disturb PC.
        step(32'h0, 32'h0000_0100, 1'b1);
        check("load_100", PC, 32'h0000_0100);
        drive(32'h10, 32'h0000_0200, 1'b1);
        #1;
        check("hold_a", PC, 32'h0000_0100);
        drive(32'h20, 32'h0000_0300, 1'b0);
        #1;
        check("hold_b", PC, 32'h0000_0100);
        drive(32'h30, 32'h0000_0400, 1'b1);
        #1;
        check("hold_c", PC, 32'h0000_0100);
        @(negedge clk);
        drive(32'h0000_0500, 32'h0000_0600, 1'b0);
        #2;
        check("hold_d", PC, 32'h0000_0100);
        @(posedge clk);
        #1;
        check("hold_edge_sampled", PC, 32'h0000_0504);

        // Asynchronous reset pulsed away from the clock edge.
        step(32'h0, 32'h0000_0100, 1'b1);
        check("preload_100", PC, 32'h0000_0100);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_cycle", PC, 32'h0000_0000);
        drive(32'h4, 32'h8, 1'b1);
        @(posedge clk);
        #1;
        check("reset_dominates_edge", PC, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("deassert_no_edge", PC, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("after_deassert_alt", PC, 32'h0000_0008);
        step(32'h0000_0008, 32'h0, 1'b0);
        check("after_deassert_seq", PC, 32'h0000_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
